// File: rtl/cdb_arbiter.sv
// Result-bus arbiter: four 1-entry holding buffers feeding a round-robin scheduler
// that drives an external 4:1 mux (buf_data0..3 + mux_select) once per cycle.

module cdb_slot #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              full,
    output logic [DATA_W-1:0] data,
    output logic [TAG_W-1:0]  tag
);

    // load only happens while empty and clear only while full, so they never collide
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= 1'b0;
            data <= '0;
            tag  <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            data <= in_data;
            tag  <= in_tag;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

module cdb_arbiter #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [3:0]            fu_valid,
    output logic [3:0]            fu_ready,
    input  logic [4*DATA_W-1:0]   fu_data,
    input  logic [4*TAG_W-1:0]    fu_tag,
    output logic [DATA_W-1:0]     buf_data0,
    output logic [DATA_W-1:0]     buf_data1,
    output logic [DATA_W-1:0]     buf_data2,
    output logic [DATA_W-1:0]     buf_data3,
    output logic [1:0]            mux_select,
    output logic                  cdb_valid,
    output logic [TAG_W-1:0]      cdb_tag
);

    localparam int NUM_FU = 4;

    logic [NUM_FU-1:0]             full;
    logic [NUM_FU-1:0]             load;
    logic [NUM_FU-1:0]             clear;
    logic [NUM_FU-1:0]             cand;
    logic [NUM_FU-1:0][DATA_W-1:0] bdata;
    logic [NUM_FU-1:0][TAG_W-1:0]  btag;
    logic [1:0]                    rr_ptr;
    logic [1:0]                    win;
    logic [1:0]                    idx;
    logic                          found;

    // ready depends only on registered state
    assign fu_ready = ~full;
    assign load     = fu_valid & ~full;

    genvar g;
    generate
        for (g = 0; g < NUM_FU; g++) begin : g_slot
            assign clear[g] = cdb_valid && (mux_select == 2'(g));

            cdb_slot #(
                .DATA_W (DATA_W),
                .TAG_W  (TAG_W)
            ) u_slot (
                .clk     (clk),
                .reset_n (reset_n),
                .flush   (flush),
                .load    (load[g]),
                .clear   (clear[g]),
                .in_data (fu_data[g*DATA_W +: DATA_W]),
                .in_tag  (fu_tag[g*TAG_W +: TAG_W]),
                .full    (full[g]),
                .data    (bdata[g]),
                .tag     (btag[g])
            );
        end
    endgenerate

    // the entry currently on the bus is leaving, so it must not be picked again
    assign cand = full & ~clear;

    always_comb begin
        found = 1'b0;
        win   = rr_ptr;
        idx   = rr_ptr;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cdb_valid  <= 1'b0;
            mux_select <= 2'd0;
            cdb_tag    <= '0;
            rr_ptr     <= 2'd0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (found) begin
            cdb_valid  <= 1'b1;
            mux_select <= win;
            cdb_tag    <= btag[win];
            rr_ptr     <= win + 2'd1;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

    assign buf_data0 = bdata[0];
    assign buf_data1 = bdata[1];
    assign buf_data2 = bdata[2];
    assign buf_data3 = bdata[3];

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized + directed bench for cdb_arbiter against a cycle-level reference model.

module tb_cdb_arbiter;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic [3:0]  fu_valid;
    logic [3:0]  fu_ready;
    logic [63:0] fu_data;
    logic [15:0] fu_tag;
    logic [15:0] buf_data0, buf_data1, buf_data2, buf_data3;
    logic [1:0]  mux_select;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;

    cdb_arbiter #(.DATA_W(16), .TAG_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .fu_valid   (fu_valid),
        .fu_ready   (fu_ready),
        .fu_data    (fu_data),
        .fu_tag     (fu_tag),
        .buf_data0  (buf_data0),
        .buf_data1  (buf_data1),
        .buf_data2  (buf_data2),
        .buf_data3  (buf_data3),
        .mux_select (mux_select),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_full [4];
    logic [15:0] m_bd   [4];
    logic [3:0]  m_bt   [4];
    bit          m_cv;
    int          m_sel;
    logic [3:0]  m_tag;
    int          m_rr;
    logic [3:0]  last_acc;

    // FU-side pending results (held until accepted)
    bit          pend [4];
    logic [15:0] pd   [4];
    logic [3:0]  pt   [4];

    function automatic logic [15:0] mux_out();
        case (mux_select)
            2'd0: return buf_data0;
            2'd1: return buf_data1;
            2'd2: return buf_data2;
            default: return buf_data3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_full[i] = 0; m_bd[i] = '0; m_bt[i] = '0;
        end
        m_cv = 0; m_sel = 0; m_tag = '0; m_rr = 0;
    endtask

    task automatic compare();
        logic [3:0] exp_rdy;
        for (int i = 0; i < 4; i++) exp_rdy[i] = ~m_full[i];
        chk("fu_ready", 32'(fu_ready), 32'(exp_rdy));
        chk("cdb_valid", 32'(cdb_valid), 32'(m_cv));
        chk("mux_select", 32'(mux_select), 32'(m_sel));
        chk("cdb_tag", 32'(cdb_tag), 32'(m_tag));
        chk("buf_data0", 32'(buf_data0), 32'(m_bd[0]));
        chk("buf_data1", 32'(buf_data1), 32'(m_bd[1]));
        chk("buf_data2", 32'(buf_data2), 32'(m_bd[2]));
        chk("buf_data3", 32'(buf_data3), 32'(m_bd[3]));
        if (m_cv) chk("bus_data", 32'(mux_out()), 32'(m_bd[m_sel]));
    endtask

    // advance one clock: model computes the post-edge state from current inputs
    task automatic step();
        bit          nf [4];
        logic [15:0] nbd [4];
        logic [3:0]  nbt [4];
        bit          ncv;
        int          nsel, nrr, w;
        logic [3:0]  ntag;
        for (int i = 0; i < 4; i++) begin
            nf[i] = m_full[i]; nbd[i] = m_bd[i]; nbt[i] = m_bt[i];
        end
        ncv = m_cv; nsel = m_sel; ntag = m_tag; nrr = m_rr;
        last_acc = '0;
        if (flush) begin
            for (int i = 0; i < 4; i++) nf[i] = 0;
            ncv = 0;
        end else begin
            w = -1;
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_rr + k) % 4;
                if (w < 0 && m_full[j] && !(m_cv && m_sel == j)) w = j;
            end
            if (w >= 0) begin
                ncv = 1; nsel = w; ntag = m_bt[w]; nrr = (w + 1) % 4;
            end else begin
                ncv = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (m_cv && m_sel == i) nf[i] = 0;
                if (fu_valid[i] && !m_full[i]) begin
                    nf[i] = 1; nbd[i] = fu_data[i*16 +: 16]; nbt[i] = fu_tag[i*4 +: 4];
                    last_acc[i] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            m_full[i] = nf[i]; m_bd[i] = nbd[i]; m_bt[i] = nbt[i];
        end
        m_cv = ncv; m_sel = nsel; m_tag = ntag; m_rr = nrr;
        compare();
    endtask

    task automatic put(input int i, input logic [15:0] d, input logic [3:0] t);
        fu_valid[i] = 1'b1;
        fu_data[i*16 +: 16] = d;
        fu_tag[i*4 +: 4] = t;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        fu_valid = '0; flush = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("rst_ready", 32'(fu_ready), 32'hF);
        chk("rst_valid", 32'(cdb_valid), 32'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; fu_valid = '0; fu_data = '0; fu_tag = '0;
        for (int i = 0; i < 4; i++) pend[i] = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        apply_reset();
        step();

        // single FU2 result: 2-cycle latency then clear
        put(2, 16'hBEEF, 4'h5);
        step();
        fu_valid = '0;
        chk("s2_ready_busy", 32'(fu_ready), 32'hB);
        step();
        chk("s2_valid", 32'(cdb_valid), 32'h1);
        chk("s2_sel", 32'(mux_select), 32'h2);
        chk("s2_tag", 32'(cdb_tag), 32'h5);
        chk("s2_bus", 32'(mux_out()), 32'hBEEF);
        step();
        chk("s2_done_valid", 32'(cdb_valid), 32'h0);
        chk("s2_done_ready", 32'(fu_ready), 32'hF);

        // rr_ptr is now 3: buffers 0 and 3 -> grant 3 then 0
        put(0, 16'h0A0A, 4'h1);
        put(3, 16'h3C3C, 4'h7);
        step();
        fu_valid = '0;
        step();
        chk("wrap_first", 32'(mux_select), 32'h3);
        chk("wrap_first_tag", 32'(cdb_tag), 32'h7);
        step();
        chk("wrap_second", 32'(mux_select), 32'h0);
        chk("wrap_second_v", 32'(cdb_valid), 32'h1);
        step();
        // rr_ptr should be 1: FU0 and FU1 together -> 1 wins
        put(0, 16'h1111, 4'h2);
        put(1, 16'h2222, 4'h3);
        step();
        fu_valid = '0;
        step();
        chk("wrap_rr1", 32'(mux_select), 32'h1);
        repeat (3) step();

        // fairness from reset
        apply_reset();
        for (int i = 0; i < 4; i++) put(i, 16'(16'hA000 + i), 4'(i + 8));
        step();
        fu_valid = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fair_sel", 32'(mux_select), 32'(i));
            chk("fair_valid", 32'(cdb_valid), 32'h1);
        end
        step();
        chk("fair_idle", 32'(cdb_valid), 32'h0);

        // flush beats accept
        put(1, 16'h5151, 4'h4);
        put(2, 16'h5252, 4'h6);
        step();
        fu_valid = '0;
        put(0, 16'hDEAD, 4'h9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        fu_valid = '0;
        chk("flush_valid", 32'(cdb_valid), 32'h0);
        chk("flush_ready", 32'(fu_ready), 32'hF);
        step();
        chk("flush_quiet", 32'(cdb_valid), 32'h0);

        // back-pressure: second result held until buffer 1 clears
        put(1, 16'hAAAA, 4'h1);
        step();
        put(1, 16'hBBBB, 4'h2);
        step();
        chk("bp_hold_data", 32'(buf_data1), 32'hAAAA);
        chk("bp_bcast", 32'(cdb_valid && mux_select == 2'd1), 32'h1);
        step();
        chk("bp_cleared", 32'(fu_ready[1]), 32'h1);
        chk("bp_no_overwrite", 32'(buf_data1), 32'hAAAA);
        step();
        fu_valid = '0;
        chk("bp_accepted", 32'(buf_data1), 32'hBBBB);
        chk("bp_busy", 32'(fu_ready[1]), 32'h0);
        step();
        chk("bp_bcast2_tag", 32'(cdb_tag), 32'h2);
        step();
        chk("bp_once", 32'(fu_ready), 32'hF);

        // asynchronous reset mid-broadcast
        put(0, 16'h7777, 4'h3);
        step();
        fu_valid = '0;
        step();
        chk("ar_pre_valid", 32'(cdb_valid), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(cdb_valid), 32'h0);
        chk("ar_ready", 32'(fu_ready), 32'hF);
        chk("ar_sel", 32'(mux_select), 32'h0);
        model_reset();
        #1;
        reset_n = 1'b1;
        step();

        // randomized traffic with holding FUs and occasional flush
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom % 3 != 0)) begin
                    pend[i] = 1; pd[i] = 16'($urandom); pt[i] = 4'($urandom);
                end
                fu_valid[i] = pend[i];
                fu_data[i*16 +: 16] = pd[i];
                fu_tag[i*4 +: 4] = pt[i];
            end
            flush = ($urandom % 25 == 0);
            step();
            for (int i = 0; i < 4; i++) if (last_acc[i]) pend[i] = 0;
        end
        flush = 1'b0;
        fu_valid = '0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
